wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_queue_if.sv | 39 +++
 rtl/wb_fwd_match.sv | 38 +++
 rtl/wb_queue.sv | 101 ++++++++++
 tb/tb_wb_queue.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared defaults and entry type for the write-back queue.
// Imported by the queue, its interface and the forwarding matcher.
package wb_pkg;

    localparam int WB_DEPTH = 4;
    localparam int WB_AW    = 5;
    localparam int WB_DW    = 32;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Bundle of ALU-side, register-file-side and bypass signals.
// slave = the queue, master = whoever drives it.
interface wb_queue_if
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [AW-1:0]            in_addr;
    logic [DW-1:0]            in_data;
    logic                     wb_we;
    logic [AW-1:0]            wb_addr;
    logic [DW-1:0]            wb_data;
    logic                     wb_hold;
    logic                     flush;
    logic [AW-1:0]            fwd_addr;
    logic                     fwd_hit;
    logic [DW-1:0]            fwd_data;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  in_valid, in_addr, in_data,
        input  wb_hold, flush, fwd_addr,
        output in_ready, wb_we, wb_addr, wb_data,
        output fwd_hit, fwd_data, count
    );

    modport master (
        output in_valid, in_addr, in_data,
        output wb_hold, flush, fwd_addr,
        input  in_ready, wb_we, wb_addr, wb_data,
        input  fwd_hit, fwd_data, count
    );

endinterface

// File: rtl/wb_fwd_match.sv
// Newest-first address match over the pending queue entries.
// Walks oldest to newest so the last hit (newest) wins.
module wb_fwd_match #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                          en_i,
    input  logic [DEPTH-1:0][AW-1:0]      ent_addr_i,
    input  logic [DEPTH-1:0][DW-1:0]      ent_data_i,
    input  logic [$clog2(DEPTH)-1:0]      head_i,
    input  logic [$clog2(DEPTH):0]        count_i,
    input  logic [AW-1:0]                 fwd_addr_i,
    output logic                          hit_o,
    output logic [DW-1:0]                 data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    // Scan age order from head; a later (younger) match overrides.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PW'(i);
            if (en_i && (CW'(i) < count_i)
                && (ent_addr_i[idx] == fwd_addr_i)) begin
                hit_o  = 1'b1;
                data_o = ent_data_i[idx];
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// In-order write-back FIFO between ALU results and the register file.
// Head drains combinationally; flush and reset drop all pending entries.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic        clk,
    input  logic        reset,
    wb_queue_if.slave   bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [PW-1:0]            head_q, head_d;
    logic [PW-1:0]            tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     not_empty;
    logic                     push;
    logic                     pop;

    // Handshake and head presentation; everything is gated by reset.
    always_comb begin
        not_empty    = (count_q != '0);
        bus.in_ready = reset && !bus.flush
                       && (count_q < CW'(DEPTH));
        bus.wb_we    = reset && not_empty
                       && !bus.wb_hold && !bus.flush;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        if (reset && not_empty) begin
            bus.wb_addr = addr_q[head_q];
            bus.wb_data = data_q[head_q];
        end
        bus.count = count_q;
        push      = bus.in_valid && bus.in_ready;
        pop       = bus.wb_we;
    end

    // Pointer and occupancy next state; flush empties the queue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; written only on an accepted push, never cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= bus.in_addr;
            data_q[tail_q] <= bus.in_data;
        end
    end

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd (
        .en_i       (reset),
        .ent_addr_i (addr_q),
        .ent_data_i (data_q),
        .head_i     (head_q),
        .count_i    (count_q),
        .fwd_addr_i (bus.fwd_addr),
        .hit_o      (bus.fwd_hit),
        .data_o     (bus.fwd_data)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: reset, drain, hold, bypass,
// back-to-back wrap, flush and mid-drain reset.
module tb_wb_queue;
    import wb_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    wb_queue_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();

    wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_addr = 5'd4;
        bus.in_data = 32'hDEAD0000;
        bus.fwd_addr = 5'd4;
        cyc();
        cyc();
        #1;
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
        total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", bus.wb_we); end
        total++; if (bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0) begin bad++; $display("FAIL rst_wbbus got=%0h/%0h exp=0/0", bus.wb_addr, bus.wb_data); end
        total++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) begin bad++; $display("FAIL rst_fwd got=%0b/%0h exp=0/0", bus.fwd_hit, bus.fwd_data); end
        reset = 1'b1;
        bus.in_valid = 1'b0;
        cyc();
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", bus.in_ready); end
        total++; if (bus.count !== 3'd0 || bus.wb_we !== 1'b0) begin bad++; $display("FAIL rst_nostore got=%0d/%0b exp=0/0", bus.count, bus.wb_we); end
        total++; if (bus.fwd_hit !== 1'b0) begin bad++; $display("FAIL rst_fwd_after got=%0b exp=0", bus.fwd_hit); end
    endtask

    task automatic test_single();
        bus.in_valid = 1'b1;
        bus.in_addr = 5'd3;
        bus.in_data = 32'hAAAA0001;
        #1;
        total++; if (bus.in_ready !== 1'b1 || bus.wb_we !== 1'b0) begin bad++; $display("FAIL single_pre got=%0b/%0b exp=1/0", bus.in_ready, bus.wb_we); end
        cyc();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.wb_we !== 1'b1) begin bad++; $display("FAIL single_we got=%0b exp=1", bus.wb_we); end
        total++; if (bus.wb_addr !== 5'd3 || bus.wb_data !== 32'hAAAA0001) begin bad++; $display("FAIL single_head got=%0d/%0h exp=3/aaaa0001", bus.wb_addr, bus.wb_data); end
        total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL single_cnt1 got=%0d exp=1", bus.count); end
        cyc();
        #1;
        total++; if (bus.count !== 3'd0 || bus.wb_we !== 1'b0) begin bad++; $display("FAIL single_empty got=%0d/%0b exp=0/0", bus.count, bus.wb_we); end
    endtask

    task automatic test_hold();
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr = 5'(i + 1);
            bus.in_data = 32'h100 + 32'(i);
            #1;
            total++; if (bus.in_ready !== (i < 4)) begin bad++; $display("FAIL hold_ready%0d got=%0b exp=%0b", i, bus.in_ready, (i < 4)); end
            cyc();
        end
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_full got=%0d/%0b exp=4/0", bus.count, bus.in_ready); end
        total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL hold_we got=%0b exp=0", bus.wb_we); end
        bus.wb_hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'(k + 1) || bus.wb_data !== 32'h100 + 32'(k)) begin bad++; $display("FAIL hold_drain%0d got=%0b/%0d/%0h exp=1/%0d/%0h", k, bus.wb_we, bus.wb_addr, bus.wb_data, k + 1, 32'h100 + 32'(k)); end
            cyc();
        end
        #1;
        total++; if (bus.count !== 3'd0 || bus.wb_we !== 1'b0) begin bad++; $display("FAIL hold_done got=%0d/%0b exp=0/0", bus.count, bus.wb_we); end
    endtask

    task automatic test_fwd();
        wb_entry_t v [3];
        v[0] = '{addr: 5'd7, data: 32'h11};
        v[1] = '{addr: 5'd7, data: 32'h22};
        v[2] = '{addr: 5'd9, data: 32'h33};
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr = v[i].addr;
            bus.in_data = v[i].data;
            cyc();
        end
        bus.in_valid = 1'b0;
        bus.fwd_addr = 5'd7;
        #1;
        total++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h22) begin bad++; $display("FAIL fwd_newest got=%0b/%0h exp=1/22", bus.fwd_hit, bus.fwd_data); end
        bus.fwd_addr = 5'd8;
        #1;
        total++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'h0) begin bad++; $display("FAIL fwd_miss got=%0b/%0h exp=0/0", bus.fwd_hit, bus.fwd_data); end
        bus.fwd_addr = 5'd9;
        #1;
        total++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h33) begin bad++; $display("FAIL fwd_tail got=%0b/%0h exp=1/33", bus.fwd_hit, bus.fwd_data); end
        bus.wb_hold = 1'b0;
        cyc();
        cyc();
        bus.fwd_addr = 5'd9;
        #1;
        total++; if (bus.wb_we !== 1'b1 || bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h33) begin bad++; $display("FAIL fwd_popping got=%0b/%0b/%0h exp=1/1/33", bus.wb_we, bus.fwd_hit, bus.fwd_data); end
        cyc();
        #1;
        total++; if (bus.count !== 3'd0 || bus.fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_drained got=%0d/%0b exp=0/0", bus.count, bus.fwd_hit); end
    endtask

    task automatic test_addr0();
        bus.in_valid = 1'b1;
        bus.in_addr = 5'd0;
        bus.in_data = 32'h5A5A;
        bus.fwd_addr = 5'd0;
        cyc();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd0 || bus.wb_data !== 32'h5A5A) begin bad++; $display("FAIL addr0_wb got=%0b/%0d/%0h exp=1/0/5a5a", bus.wb_we, bus.wb_addr, bus.wb_data); end
        total++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h5A5A) begin bad++; $display("FAIL addr0_fwd got=%0b/%0h exp=1/5a5a", bus.fwd_hit, bus.fwd_data); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ea;
        logic [31:0] ed;
        bus.wb_hold = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_addr = 5'd10;
        bus.in_data = 32'hA0;
        cyc();
        bus.in_addr = 5'd11;
        bus.in_data = 32'hA1;
        cyc();
        bus.wb_hold = 1'b0;
        for (int c = 0; c < 12; c++) begin
            bus.in_valid = (c < 10);
            bus.in_addr = 5'(12 + c);
            bus.in_data = 32'hB0 + 32'(c);
            if (c < 2) begin
                ea = 5'(10 + c);
                ed = 32'hA0 + 32'(c);
            end else begin
                ea = 5'(12 + c - 2);
                ed = 32'hB0 + 32'(c - 2);
            end
            #1;
            if (c < 10) begin
                total++; if (bus.count !== 3'd2) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=2", c, bus.count); end
            end
            total++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== ea || bus.wb_data !== ed) begin bad++; $display("FAIL b2b_order%0d got=%0b/%0d/%0h exp=1/%0d/%0h", c, bus.wb_we, bus.wb_addr, bus.wb_data, ea, ed); end
            cyc();
        end
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.count !== 3'd0 || bus.wb_we !== 1'b0) begin bad++; $display("FAIL b2b_done got=%0d/%0b exp=0/0", bus.count, bus.wb_we); end
    endtask

    task automatic test_flush();
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr = 5'(i + 1);
            bus.in_data = 32'hC0 + 32'(i);
            cyc();
        end
        #1;
        total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d exp=3", bus.count); end
        bus.wb_hold = 1'b0;
        bus.flush = 1'b1;
        bus.in_addr = 5'd20;
        bus.in_data = 32'hFF;
        #1;
        total++; if (bus.wb_we !== 1'b0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_we got=%0b/%0b exp=0/0", bus.wb_we, bus.in_ready); end
        cyc();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.count !== 3'd0 || bus.wb_we !== 1'b0 || bus.wb_addr !== 5'd0) begin bad++; $display("FAIL flush_empty got=%0d/%0b/%0d exp=0/0/0", bus.count, bus.wb_we, bus.wb_addr); end
        cyc();
        #1;
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL flush_nostore got=%0d exp=0", bus.count); end
    endtask

    task automatic test_reset_mid();
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr = 5'(i + 1);
            bus.in_data = 32'h60 + 32'(i);
            cyc();
        end
        bus.in_valid = 1'b0;
        bus.wb_hold = 1'b0;
        cyc();
        #1;
        total++; if (bus.count !== 3'd2 || bus.wb_addr !== 5'd2) begin bad++; $display("FAIL rmid_pre got=%0d/%0d exp=2/2", bus.count, bus.wb_addr); end
        reset = 1'b0;
        bus.fwd_addr = 5'd2;
        #1;
        total++; if (bus.wb_we !== 1'b0 || bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0) begin bad++; $display("FAIL rmid_out got=%0b/%0d/%0h exp=0/0/0", bus.wb_we, bus.wb_addr, bus.wb_data); end
        total++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) begin bad++; $display("FAIL rmid_fwd got=%0b/%0h exp=0/0", bus.fwd_hit, bus.fwd_data); end
        cyc();
        reset = 1'b1;
        #1;
        total++; if (bus.count !== 3'd0 || bus.wb_we !== 1'b0) begin bad++; $display("FAIL rmid_after got=%0d/%0b exp=0/0", bus.count, bus.wb_we); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL rmid_quiet%0d got=%0b exp=0", k, bus.wb_we); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_addr = '0;
        bus.in_data = '0;
        bus.wb_hold = 1'b0;
        bus.flush = 1'b0;
        bus.fwd_addr = '0;
        test_reset();
        test_single();
        test_hold();
        test_fwd();
        test_addr0();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
